// File: rtl/hni_pcrdgnt_pkg.sv
// Shared definitions for the home-node PCrdGrant generator: RSP flit layout,
// the PCrdGrant opcode and a helper that assembles a grant flit.
package hni_pcrdgnt_pkg;

  localparam int PCRD_TYPE_NUM_DEF = 4;
  localparam int RETRY_Q_DEPTH_DEF = 16;
  localparam int CRD_CNT_WIDTH_DEF = 5;

  // RSP flit field widths and positions (QoS occupies the low nibble).
  localparam int CHIE_RSP_FLIT_TGTID_WIDTH    = 11;
  localparam int CHIE_RSP_FLIT_SRCID_WIDTH    = 11;
  localparam int CHIE_RSP_FLIT_OPCODE_WIDTH   = 5;
  localparam int CHIE_RSP_FLIT_PCRDTYPE_WIDTH = 4;
  localparam int CHIE_RSP_FLIT_WIDTH          = 73;

  localparam int CHIE_RSP_FLIT_TGTID_LSB    = 4;
  localparam int CHIE_RSP_FLIT_SRCID_LSB    = 15;
  localparam int CHIE_RSP_FLIT_OPCODE_LSB   = 38;
  localparam int CHIE_RSP_FLIT_PCRDTYPE_LSB = 66;

  localparam logic [CHIE_RSP_FLIT_OPCODE_WIDTH-1:0] CHIE_PCRDGRANT = 5'h07;

  typedef logic [CHIE_RSP_FLIT_SRCID_WIDTH-1:0] chie_nodeid_t;
  typedef logic [CHIE_RSP_FLIT_WIDTH-1:0]       chie_rsp_flit_t;

  function automatic chie_rsp_flit_t build_pcrdgrant(
    input logic [CHIE_RSP_FLIT_TGTID_WIDTH-1:0]    tgt,
    input logic [CHIE_RSP_FLIT_SRCID_WIDTH-1:0]    src,
    input logic [CHIE_RSP_FLIT_PCRDTYPE_WIDTH-1:0] pcrd
  );
    chie_rsp_flit_t f;
    f = '0;
    f[CHIE_RSP_FLIT_OPCODE_LSB   +: CHIE_RSP_FLIT_OPCODE_WIDTH]   = CHIE_PCRDGRANT;
    f[CHIE_RSP_FLIT_TGTID_LSB    +: CHIE_RSP_FLIT_TGTID_WIDTH]    = tgt;
    f[CHIE_RSP_FLIT_SRCID_LSB    +: CHIE_RSP_FLIT_SRCID_WIDTH]    = src;
    f[CHIE_RSP_FLIT_PCRDTYPE_LSB +: CHIE_RSP_FLIT_PCRDTYPE_WIDTH] = pcrd;
    return f;
  endfunction

endpackage

// File: rtl/hni_pcrdgnt_ctl_sync_fifo.sv
// Synchronous FIFO holding retried requester IDs; the head is read from storage
// only, so a pushed entry is first visible on the cycle after the push.
module hni_pcrdgnt_ctl_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/hni_pcrdgnt_ctl.sv
// Home-side PCrdGrant generator: matches retried requesters with released tracker
// credits per PCrdType and emits PCrdGrant flits on TXRSP.
module hni_pcrdgnt_ctl
  import hni_pcrdgnt_pkg::*;
#(
  parameter int PCRD_TYPE_NUM = PCRD_TYPE_NUM_DEF,
  parameter int RETRY_Q_DEPTH = RETRY_Q_DEPTH_DEF,
  parameter int CRD_CNT_WIDTH = CRD_CNT_WIDTH_DEF
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    retry_v_i,
  input  logic [CHIE_RSP_FLIT_SRCID_WIDTH-1:0]    retry_srcid_i,
  input  logic [CHIE_RSP_FLIT_PCRDTYPE_WIDTH-1:0] retry_pcrdtype_i,
  output logic [PCRD_TYPE_NUM-1:0]                retry_full_o,
  input  logic                                    crd_rel_v_i,
  input  logic [CHIE_RSP_FLIT_PCRDTYPE_WIDTH-1:0] crd_rel_type_i,
  input  logic [CHIE_RSP_FLIT_TGTID_WIDTH-1:0]    hn_id_i,
  output logic                                    txrspflitv_o,
  output logic [CHIE_RSP_FLIT_WIDTH-1:0]          txrspflit_o,
  input  logic                                    txrsp_rdy_i,
  output logic                                    err_ovf_o
);

  localparam int RR_W = (PCRD_TYPE_NUM > 1) ? $clog2(PCRD_TYPE_NUM) : 1;

  logic [PCRD_TYPE_NUM-1:0] q_push, q_pop, q_full, q_empty, elig;
  chie_nodeid_t             q_head [PCRD_TYPE_NUM];
  logic [CRD_CNT_WIDTH-1:0] crd_cnt_q [PCRD_TYPE_NUM];
  logic [CRD_CNT_WIDTH-1:0] crd_cnt_d [PCRD_TYPE_NUM];
  logic [RR_W-1:0]          rr_q, rr_d, win;
  logic                     found, grant, slot_free;
  logic                     flitv_q, flitv_d;
  chie_rsp_flit_t           flit_q, flit_d;
  logic                     err_q, err_d;
  logic                     retry_drop, crd_bad, crd_sat;

  for (genvar g = 0; g < PCRD_TYPE_NUM; g++) begin : g_retry_q
    hni_pcrdgnt_ctl_sync_fifo #(
      .WIDTH (CHIE_RSP_FLIT_SRCID_WIDTH),
      .DEPTH (RETRY_Q_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (q_push[g]),
      .data_i  (retry_srcid_i),
      .pop_i   (q_pop[g]),
      .data_o  (q_head[g]),
      .full_o  (q_full[g]),
      .empty_o (q_empty[g])
    );
  end

  always_comb begin
    q_push     = '0;
    retry_drop = retry_v_i && (int'(retry_pcrdtype_i) >= PCRD_TYPE_NUM);
    for (int t = 0; t < PCRD_TYPE_NUM; t++) begin
      if (retry_v_i && int'(retry_pcrdtype_i) == t) begin
        q_push[t] = !q_full[t];
        if (q_full[t]) retry_drop = 1'b1;
      end
    end
  end

  // A release and a grant on the same type cancel; saturation only matters for a lone increment.
  always_comb begin
    crd_bad = crd_rel_v_i && (int'(crd_rel_type_i) >= PCRD_TYPE_NUM);
    crd_sat = 1'b0;
    for (int t = 0; t < PCRD_TYPE_NUM; t++) begin
      crd_cnt_d[t] = crd_cnt_q[t];
      elig[t]      = !q_empty[t] && (crd_cnt_q[t] != '0);
      if (crd_rel_v_i && int'(crd_rel_type_i) == t && !q_pop[t]) begin
        if (&crd_cnt_q[t]) crd_sat = 1'b1;
        else               crd_cnt_d[t] = crd_cnt_q[t] + CRD_CNT_WIDTH'(1);
      end else if (q_pop[t] && !(crd_rel_v_i && int'(crd_rel_type_i) == t)) begin
        crd_cnt_d[t] = crd_cnt_q[t] - CRD_CNT_WIDTH'(1);
      end
    end
  end

  // Round-robin search starting at rr_q; only runs when the output slot frees up.
  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < PCRD_TYPE_NUM; i++) begin
      idx = (int'(rr_q) + i) % PCRD_TYPE_NUM;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = RR_W'(idx);
      end
    end
    slot_free = !flitv_q || txrsp_rdy_i;
    grant     = slot_free && found;
    q_pop     = '0;
    if (grant) q_pop[win] = 1'b1;
    rr_d = rr_q;
    if (grant) rr_d = (int'(win) == PCRD_TYPE_NUM - 1) ? '0 : win + RR_W'(1);
  end

  always_comb begin
    flitv_d = flitv_q && !txrsp_rdy_i;
    flit_d  = flit_q;
    if (grant) begin
      flitv_d = 1'b1;
      flit_d  = build_pcrdgrant(q_head[win], hn_id_i,
                                CHIE_RSP_FLIT_PCRDTYPE_WIDTH'(win));
    end
    err_d = err_q || retry_drop || crd_bad || crd_sat;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < PCRD_TYPE_NUM; t++) crd_cnt_q[t] <= '0;
      rr_q    <= '0;
      flitv_q <= 1'b0;
      flit_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int t = 0; t < PCRD_TYPE_NUM; t++) crd_cnt_q[t] <= crd_cnt_d[t];
      rr_q    <= rr_d;
      flitv_q <= flitv_d;
      flit_q  <= flit_d;
      err_q   <= err_d;
    end
  end

  assign retry_full_o = q_full;
  assign txrspflitv_o = flitv_q;
  assign txrspflit_o  = flit_q;
  assign err_ovf_o    = err_q;

endmodule

// File: tb/tb_hni_pcrdgnt_ctl.sv
// Directed self-checking bench for hni_pcrdgnt_ctl; expected flits use
// hand-placed field positions independent of the design package.
module tb_hni_pcrdgnt_ctl;
  import hni_pcrdgnt_pkg::*;

  localparam logic [10:0] HN_ID = 11'h155;

  logic        clk, rst;
  logic        retryV;
  logic [10:0] retrySrc;
  logic [3:0]  retryType;
  logic [3:0]  retryFull;
  logic        crdV;
  logic [3:0]  crdType;
  logic        txV;
  logic [CHIE_RSP_FLIT_WIDTH-1:0] txFlit;
  logic        txRdy;
  logic        errOvf;

  int cmpCount  = 0;
  int failCount = 0;

  hni_pcrdgnt_ctl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .retry_v_i        (retryV),
    .retry_srcid_i    (retrySrc),
    .retry_pcrdtype_i (retryType),
    .retry_full_o     (retryFull),
    .crd_rel_v_i      (crdV),
    .crd_rel_type_i   (crdType),
    .hn_id_i          (HN_ID),
    .txrspflitv_o     (txV),
    .txrspflit_o      (txFlit),
    .txrsp_rdy_i      (txRdy),
    .err_ovf_o        (errOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [72:0] expFlit(input logic [10:0] tgt, input logic [3:0] pt);
    logic [72:0] f;
    f        = '0;
    f[42:38] = 5'h07;
    f[14:4]  = tgt;
    f[25:15] = HN_ID;
    f[69:66] = pt;
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs;
    retryV = 1'b0; retrySrc = '0; retryType = '0;
    crdV = 1'b0; crdType = '0;
  endtask

  task automatic doReset;
    clearInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    txRdy = 1'b1;
    doReset();
    cmpCount++;
    if (txV !== 1'b0) begin failCount++; $display("[TB] FAIL rst_valid: got %0b want 0", txV); end
    cmpCount++;
    if (txFlit !== '0) begin failCount++; $display("[TB] FAIL rst_flit: got %h want 0", txFlit); end
    cmpCount++;
    if (errOvf !== 1'b0) begin failCount++; $display("[TB] FAIL rst_err: got %0b want 0", errOvf); end
    cmpCount++;
    if (retryFull !== 4'b0) begin failCount++; $display("[TB] FAIL rst_full: got %b want 0000", retryFull); end
    cmpCount++;
    if (dut.rr_q !== 2'd0) begin failCount++; $display("[TB] FAIL rst_rr: got %0d want 0", dut.rr_q); end
  endtask

  task automatic test_single_grant;
    txRdy = 1'b1;
    retryV = 1'b1; retrySrc = 11'h12; retryType = 4'd1;
    tick();
    clearInputs();
    tick();
    crdV = 1'b1; crdType = 4'd1;
    tick();
    clearInputs();
    cmpCount++;
    if (txV !== 1'b0) begin failCount++; $display("[TB] FAIL t1_early: got %0b want 0", txV); end
    tick();
    cmpCount++;
    if (txV !== 1'b1) begin failCount++; $display("[TB] FAIL t1_valid: got %0b want 1", txV); end
    cmpCount++;
    if (txFlit !== expFlit(11'h12, 4'd1)) begin failCount++; $display("[TB] FAIL t1_flit: got %h want %h", txFlit, expFlit(11'h12, 4'd1)); end
    cmpCount++;
    if (dut.crd_cnt_q[1] !== 5'd0) begin failCount++; $display("[TB] FAIL t1_cnt: got %0d want 0", dut.crd_cnt_q[1]); end
    tick();
    cmpCount++;
    if (txV !== 1'b0) begin failCount++; $display("[TB] FAIL t1_drop: got %0b want 0", txV); end
  endtask

  task automatic test_fifo_order;
    txRdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      crdV = 1'b1; crdType = 4'd0;
      tick();
    end
    clearInputs();
    for (int i = 1; i <= 3; i++) begin
      retryV = 1'b1; retrySrc = 11'(i); retryType = 4'd0;
      tick();
      cmpCount++;
      if (i == 1) begin
        if (txV !== 1'b0) begin failCount++; $display("[TB] FAIL t2_lat: got %0b want 0", txV); end
      end else if (txV !== 1'b1 || txFlit !== expFlit(11'(i - 1), 4'd0)) begin
        failCount++; $display("[TB] FAIL t2_order%0d: got v=%0b %h want %h", i - 1, txV, txFlit, expFlit(11'(i - 1), 4'd0));
      end
    end
    clearInputs();
    tick();
    cmpCount++;
    if (txV !== 1'b1 || txFlit !== expFlit(11'h3, 4'd0)) begin failCount++; $display("[TB] FAIL t2_order3: got v=%0b %h want %h", txV, txFlit, expFlit(11'h3, 4'd0)); end
    tick();
    cmpCount++;
    if (txV !== 1'b0) begin failCount++; $display("[TB] FAIL t2_idle: got %0b want 0", txV); end
    cmpCount++;
    if (dut.crd_cnt_q[0] !== 5'd0) begin failCount++; $display("[TB] FAIL t2_cnt: got %0d want 0", dut.crd_cnt_q[0]); end
  endtask

  task automatic test_round_robin;
    logic [10:0] expTgt [4];
    logic [3:0]  expPt  [4];
    logic [10:0] loadSrc [4];
    logic [3:0]  loadPt  [4];
    expTgt = '{11'h0A, 11'h2C, 11'h0B, 11'h2D};
    expPt  = '{4'd0, 4'd2, 4'd0, 4'd2};
    loadSrc = '{11'h0A, 11'h0B, 11'h2C, 11'h2D};
    loadPt  = '{4'd0, 4'd0, 4'd2, 4'd2};
    txRdy = 1'b0;
    doReset();
    retryV = 1'b1; retrySrc = 11'h30; retryType = 4'd3;
    crdV = 1'b1; crdType = 4'd3;
    tick();
    clearInputs();
    tick();
    cmpCount++;
    if (txV !== 1'b1 || txFlit !== expFlit(11'h30, 4'd3)) begin failCount++; $display("[TB] FAIL t3_block: got v=%0b %h want %h", txV, txFlit, expFlit(11'h30, 4'd3)); end
    for (int i = 0; i < 4; i++) begin
      retryV = 1'b1; retrySrc = loadSrc[i]; retryType = loadPt[i];
      crdV = 1'b1; crdType = loadPt[i];
      tick();
    end
    clearInputs();
    tick();
    cmpCount++;
    if (txFlit !== expFlit(11'h30, 4'd3)) begin failCount++; $display("[TB] FAIL t3_hold: got %h want %h", txFlit, expFlit(11'h30, 4'd3)); end
    txRdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmpCount++;
      if (txV !== 1'b1 || txFlit !== expFlit(expTgt[i], expPt[i])) begin
        failCount++; $display("[TB] FAIL t3_rr%0d: got v=%0b %h want %h", i, txV, txFlit, expFlit(expTgt[i], expPt[i]));
      end
    end
    tick();
    cmpCount++;
    if (txV !== 1'b0) begin failCount++; $display("[TB] FAIL t3_idle: got %0b want 0", txV); end
    cmpCount++;
    if (dut.rr_q !== 2'd3) begin failCount++; $display("[TB] FAIL t3_rrptr: got %0d want 3", dut.rr_q); end
  endtask

  task automatic test_backpressure;
    txRdy = 1'b0;
    retryV = 1'b1; retrySrc = 11'h41; retryType = 4'd1;
    crdV = 1'b1; crdType = 4'd1;
    tick();
    clearInputs();
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        retryV = 1'b1; retrySrc = 11'h42; retryType = 4'd1;
        crdV = 1'b1; crdType = 4'd1;
      end else begin
        clearInputs();
      end
      tick();
      cmpCount++;
      if (txV !== 1'b1 || txFlit !== expFlit(11'h41, 4'd1)) begin
        failCount++; $display("[TB] FAIL t4_stall%0d: got v=%0b %h want %h", i, txV, txFlit, expFlit(11'h41, 4'd1));
      end
    end
    clearInputs();
    cmpCount++;
    if (dut.crd_cnt_q[1] !== 5'd1) begin failCount++; $display("[TB] FAIL t4_cnt_held: got %0d want 1", dut.crd_cnt_q[1]); end
    txRdy = 1'b1;
    tick();
    cmpCount++;
    if (txV !== 1'b1 || txFlit !== expFlit(11'h42, 4'd1)) begin failCount++; $display("[TB] FAIL t4_next: got v=%0b %h want %h", txV, txFlit, expFlit(11'h42, 4'd1)); end
    cmpCount++;
    if (dut.crd_cnt_q[1] !== 5'd0) begin failCount++; $display("[TB] FAIL t4_cnt_after: got %0d want 0", dut.crd_cnt_q[1]); end
    tick();
    cmpCount++;
    if (txV !== 1'b0) begin failCount++; $display("[TB] FAIL t4_idle: got %0b want 0", txV); end
  endtask

  task automatic test_queue_full;
    txRdy = 1'b1;
    doReset();
    for (int i = 0; i < 17; i++) begin
      retryV = 1'b1; retrySrc = 11'(i); retryType = 4'd3;
      tick();
      if (i == 14) begin
        cmpCount++;
        if (retryFull !== 4'b0000) begin failCount++; $display("[TB] FAIL t5_full15: got %b want 0000", retryFull); end
      end else if (i == 15) begin
        cmpCount++;
        if (retryFull !== 4'b1000 || errOvf !== 1'b0) begin failCount++; $display("[TB] FAIL t5_full16: got %b err=%0b want 1000 err=0", retryFull, errOvf); end
      end else if (i == 16) begin
        cmpCount++;
        if (retryFull !== 4'b1000 || errOvf !== 1'b1) begin failCount++; $display("[TB] FAIL t5_drop: got %b err=%0b want 1000 err=1", retryFull, errOvf); end
      end
    end
    clearInputs();
    tick();
    tick();
    cmpCount++;
    if (errOvf !== 1'b1) begin failCount++; $display("[TB] FAIL t5_sticky: got %0b want 1", errOvf); end
    txRdy = 1'b0;
    crdV = 1'b1; crdType = 4'd3;
    tick();
    clearInputs();
    tick();
    cmpCount++;
    if (txV !== 1'b1 || txFlit !== expFlit(11'h0, 4'd3)) begin failCount++; $display("[TB] FAIL t5_pending: got v=%0b %h want %h", txV, txFlit, expFlit(11'h0, 4'd3)); end
    doReset();
    cmpCount++;
    if (txV !== 1'b0 || txFlit !== '0 || errOvf !== 1'b0 || retryFull !== 4'b0) begin
      failCount++; $display("[TB] FAIL t5_reset: got v=%0b flit=%h err=%0b full=%b want all 0", txV, txFlit, errOvf, retryFull);
    end
    txRdy = 1'b1;
    crdV = 1'b1; crdType = 4'd3;
    tick();
    clearInputs();
    tick();
    tick();
    cmpCount++;
    if (txV !== 1'b0) begin failCount++; $display("[TB] FAIL t5_flushed: got %0b want 0", txV); end
  endtask

  task automatic test_coincident;
    txRdy = 1'b1;
    doReset();
    crdV = 1'b1; crdType = 4'd2;
    tick();
    clearInputs();
    retryV = 1'b1; retrySrc = 11'h61; retryType = 4'd2;
    tick();
    clearInputs();
    crdV = 1'b1; crdType = 4'd2;
    tick();
    clearInputs();
    cmpCount++;
    if (txV !== 1'b1 || txFlit !== expFlit(11'h61, 4'd2)) begin failCount++; $display("[TB] FAIL t6_grant: got v=%0b %h want %h", txV, txFlit, expFlit(11'h61, 4'd2)); end
    cmpCount++;
    if (dut.crd_cnt_q[2] !== 5'd1) begin failCount++; $display("[TB] FAIL t6_cnt: got %0d want 1", dut.crd_cnt_q[2]); end
    cmpCount++;
    if (errOvf !== 1'b0) begin failCount++; $display("[TB] FAIL t6_noerr: got %0b want 0", errOvf); end
    crdV = 1'b1; crdType = 4'd7;
    tick();
    clearInputs();
    cmpCount++;
    if (errOvf !== 1'b1) begin failCount++; $display("[TB] FAIL t6_badtype: got %0b want 1", errOvf); end
    cmpCount++;
    if (dut.crd_cnt_q[2] !== 5'd1 || dut.crd_cnt_q[3] !== 5'd0) begin failCount++; $display("[TB] FAIL t6_ignored: got c2=%0d c3=%0d want 1 0", dut.crd_cnt_q[2], dut.crd_cnt_q[3]); end
  endtask

  task automatic test_bad_retry_type;
    txRdy = 1'b1;
    doReset();
    retryV = 1'b1; retrySrc = 11'h77; retryType = 4'd9;
    tick();
    clearInputs();
    cmpCount++;
    if (errOvf !== 1'b1) begin failCount++; $display("[TB] FAIL t7_err: got %0b want 1", errOvf); end
    for (int t = 0; t < 4; t++) begin
      crdV = 1'b1; crdType = 4'(t);
      tick();
    end
    clearInputs();
    tick();
    tick();
    cmpCount++;
    if (txV !== 1'b0 || retryFull !== 4'b0) begin failCount++; $display("[TB] FAIL t7_nopush: got v=%0b full=%b want 0 0000", txV, retryFull); end
  endtask

  task automatic test_crd_saturate;
    txRdy = 1'b1;
    doReset();
    for (int i = 0; i < 31; i++) begin
      crdV = 1'b1; crdType = 4'd0;
      tick();
    end
    cmpCount++;
    if (dut.crd_cnt_q[0] !== 5'd31 || errOvf !== 1'b0) begin failCount++; $display("[TB] FAIL t8_max: got %0d err=%0b want 31 err=0", dut.crd_cnt_q[0], errOvf); end
    tick();
    clearInputs();
    cmpCount++;
    if (dut.crd_cnt_q[0] !== 5'd31 || errOvf !== 1'b1) begin failCount++; $display("[TB] FAIL t8_sat: got %0d err=%0b want 31 err=1", dut.crd_cnt_q[0], errOvf); end
  endtask

  initial begin
    rst = 1'b1;
    txRdy = 1'b1;
    clearInputs();
    tick();
    test_reset();
    test_single_grant();
    test_fifo_order();
    test_round_robin();
    test_backpressure();
    test_queue_full();
    test_coincident();
    test_bad_retry_type();
    test_crd_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
